// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file access arbiter: FSM states, requester index, requester count.
package regfile_arb_pkg;
   localparam int NUM_REQ = 2;

   typedef logic req_idx_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RD
   } arb_state_e;

   function automatic logic [NUM_REQ-1:0] idx_onehot(input req_idx_t idx);
      logic [NUM_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction
endpackage

// File: rtl/regfile_arb_rr_pick.sv
// Combinational round-robin winner select between two requesters; the caller owns the pointer.
module regfile_arb_rr_pick
   import regfile_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_i,
   input  req_idx_t           last_i,
   output logic               valid_o,
   output req_idx_t           win_o
);

   always_comb begin
      valid_o = |req_i;
      win_o   = 1'b0;
      if (req_i == 2'b10) begin
         win_o = 1'b1;
      end else if (req_i == 2'b11) begin
         // On a tie the requester that did not win last time goes next.
         win_o = ~last_i;
      end
   end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Two-master round-robin arbiter in front of the single register-file port.
// Optional read timeout is enabled with `define ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for a request, arbitrates and latches the winner's command
// ISSUE   | grant pulse and one-cycle WrEN/RdEN strobe on the register file
// WAIT_RD | read outstanding, waiting for RDData_Valid (or timeout)
module regfile_access_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 4,
   parameter int REG_DATA_WIDTH = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                                CLK,
   input  logic                                RST,
   input  logic [NUM_REQ-1:0]                  req_i,
   input  logic [NUM_REQ-1:0]                  we_i,
   input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]    addr_i,
   input  logic [NUM_REQ*REG_DATA_WIDTH-1:0]   wdata_i,
   output logic [NUM_REQ-1:0]                  gnt_o,
   output logic [REG_DATA_WIDTH-1:0]           rdata_o,
   output logic [NUM_REQ-1:0]                  rvalid_o,
   output logic                                rd_err_o,
   output logic [ADDRESS_WIDTH-1:0]            Address,
   output logic                                WrEN,
   output logic                                RdEN,
   output logic [REG_DATA_WIDTH-1:0]           Wr_D,
   input  logic [REG_DATA_WIDTH-1:0]           Rd_D,
   input  logic                                RDData_Valid
);

   arb_state_e                  state_q;
   req_idx_t                    last_q;
   req_idx_t                    win_q;
   logic                        we_q;
   logic [NUM_REQ-1:0]          gnt_q;
   logic [NUM_REQ-1:0]          rvalid_q;
   logic [REG_DATA_WIDTH-1:0]   rdata_q;
   logic [ADDRESS_WIDTH-1:0]    addr_q;
   logic [REG_DATA_WIDTH-1:0]   wrd_q;
   logic                        wren_q;
   logic                        rden_q;

   logic                        pick_valid;
   req_idx_t                    pick_win;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0]            cnt_q;
   logic                        rd_err_q;
`else
   logic                        unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   regfile_arb_rr_pick u_pick (
      .req_i   (req_i),
      .last_i  (last_q),
      .valid_o (pick_valid),
      .win_o   (pick_win)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         win_q    <= 1'b0;
         we_q     <= 1'b0;
         gnt_q    <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         addr_q   <= '0;
         wrd_q    <= '0;
         wren_q   <= 1'b0;
         rden_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q    <= '0;
         rd_err_q <= 1'b0;
`endif
      end else begin
         // Pulse outputs default low; each state raises them for a single cycle.
         gnt_q    <= '0;
         rvalid_q <= '0;
         wren_q   <= 1'b0;
         rden_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         rd_err_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  win_q   <= pick_win;
                  last_q  <= pick_win;
                  we_q    <= we_i[pick_win];
                  addr_q  <= addr_i[int'(pick_win)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                  wrd_q   <= wdata_i[int'(pick_win)*REG_DATA_WIDTH +: REG_DATA_WIDTH];
                  gnt_q   <= idx_onehot(pick_win);
                  wren_q  <= we_i[pick_win];
                  rden_q  <= ~we_i[pick_win];
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               state_q <= we_q ? IDLE : WAIT_RD;
`ifdef ARB_TIMEOUT_EN
               cnt_q   <= CNT_W'(TIMEOUT_CYCLES - 1);
`endif
            end
            WAIT_RD: begin
               if (RDData_Valid) begin
                  rdata_q  <= Rd_D;
                  rvalid_q <= idx_onehot(win_q);
                  state_q  <= IDLE;
               end
`ifdef ARB_TIMEOUT_EN
               else if (cnt_q == '0) begin
                  rdata_q  <= '0;
                  rvalid_q <= idx_onehot(win_q);
                  rd_err_q <= 1'b1;
                  state_q  <= IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt_o    = gnt_q;
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign Address  = addr_q;
   assign Wr_D     = wrd_q;
   assign WrEN     = wren_q;
   assign RdEN     = rden_q;
`ifdef ARB_TIMEOUT_EN
   assign rd_err_o = rd_err_q;
`else
   assign rd_err_o = 1'b0;
`endif

endmodule
